// File: rtl/control_unit_pipe_if.sv
// Decode-to-execute control bus for control_unit_pipe.
// It carries the D-stage instruction handshake and the registered E-stage control outputs.
interface control_unit_pipe_if #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned CNT_W     = 8
);
  logic [31:0]          instr_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 stall_i;
  logic                 flush_i;
  logic                 valid_o;
  logic                 regwriteE;
  logic [1:0]           resultsrcE;
  logic                 memwriteE;
  logic                 branchE;
  logic                 jumpE;
  logic                 alusrcE;
  logic [2:0]           immsrcE;
  logic [ALUCTRL_W-1:0] alucontrolE;
  logic                 illegal_o;
  logic [CNT_W-1:0]     illegal_cnt_o;

  // The master drives instructions and pipeline control, and observes the E stage.
  modport master (
    output instr_i, valid_i, stall_i, flush_i,
    input  ready_o, valid_o, regwriteE, resultsrcE, memwriteE, branchE, jumpE,
           alusrcE, immsrcE, alucontrolE, illegal_o, illegal_cnt_o
  );

  // The slave (control_unit_pipe) decodes the instruction and drives the E stage.
  modport slave (
    input  instr_i, valid_i, stall_i, flush_i,
    output ready_o, valid_o, regwriteE, resultsrcE, memwriteE, branchE, jumpE,
           alusrcE, immsrcE, alucontrolE, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/control_unit_pipe.sv
// RV32 main/ALU decoder with a registered E-stage control register.
// It also keeps a saturating counter of captured illegal instructions.
// The optional macro CU_JUMP_EN enables decoding of JAL/JALR.
// Without it, those opcodes are reported as illegal and jumpE is tied to 0.
module control_unit_pipe #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned CNT_W     = 8
) (
  input logic              clk,
  input logic              rst,
  control_unit_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
    logic                 branch;
    logic                 jump;
    logic                 alusrc;
    logic [2:0]           immsrc;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic                 illegal;
  } ctrl_t;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  alu_op_e          arith_op;
  ctrl_t            dec;
  ctrl_t            e_d, e_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             unused_instr;

  assign opcode       = bus.instr_i[6:0];
  assign funct3       = bus.instr_i[14:12];
  assign funct7b5     = bus.instr_i[30];
  assign unused_instr = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

  assign bus.ready_o = !bus.stall_i;

  // Operation chosen by funct3 for R-type and I-ALU.
  // funct7b5 selects SRA for both formats; only R-type also uses it to select SUB.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (funct7b5 && opcode == OP_RTYPE) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // Main decoder: control fields for the current D-stage instruction.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_LOAD: begin
        dec.regwrite  = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 2'b01;
        dec.immsrc    = 3'b000;
        dec.aluctrl   = ALUCTRL_W'(ALU_ADD);
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'b001;
        dec.aluctrl  = ALUCTRL_W'(ALU_ADD);
      end
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        dec.aluctrl  = ALUCTRL_W'(arith_op);
      end
      OP_IALU: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'b000;
        dec.aluctrl  = ALUCTRL_W'(arith_op);
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.immsrc  = 3'b010;
        dec.aluctrl = ALUCTRL_W'(ALU_SUB);
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'b100;
        dec.aluctrl  = ALUCTRL_W'(ALU_PASSB);
      end
`ifdef CU_JUMP_EN
      OP_JAL: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = 2'b10;
        dec.immsrc    = 3'b011;
      end
      OP_JALR: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 2'b10;
        dec.immsrc    = 3'b000;
        dec.aluctrl   = ALUCTRL_W'(ALU_ADD);
      end
`endif
      default: dec.illegal = 1'b1;
    endcase
  end

  // Next E-stage state. Flush beats stall, and stall beats capture.
  // Only a captured, valid, illegal instruction advances the counter.
  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (bus.flush_i) begin
      e_d = '0;
    end else if (!bus.stall_i) begin
      if (bus.valid_i) begin
        e_d       = dec;
        e_d.valid = 1'b1;
        if (dec.illegal && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        e_d = '0;
      end
    end
  end

  // E-stage register and counter. Reset overrides flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.valid_o       = e_q.valid;
  assign bus.regwriteE     = e_q.regwrite;
  assign bus.resultsrcE    = e_q.resultsrc;
  assign bus.memwriteE     = e_q.memwrite;
  assign bus.branchE       = e_q.branch;
  assign bus.alusrcE       = e_q.alusrc;
  assign bus.immsrcE       = e_q.immsrc;
  assign bus.alucontrolE   = e_q.aluctrl;
  assign bus.illegal_o     = e_q.illegal;
  assign bus.illegal_cnt_o = cnt_q;
`ifdef CU_JUMP_EN
  assign bus.jumpE         = e_q.jump;
`else
  assign bus.jumpE         = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// Randomized self-checking bench for control_unit_pipe.
// The reference model decodes each instruction from the opcode tables.
// It then applies reset > flush > stall > capture at every edge.
module tb_control_unit_pipe;
  localparam int unsigned AW   = 4;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_pipe_if #(.ALUCTRL_W(AW), .CNT_W(CW)) bus();

  control_unit_pipe #(.ALUCTRL_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       valid;
    logic       regw;
    logic [1:0] rsrc;
    logic       memw;
    logic       br;
    logic       jmp;
    logic       asrc;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  exp_t m;
  int   mcnt;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ALU code by funct3: ADD SLL SLT SLTU XOR SRL OR AND
  int alu_tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  logic [6:0] op_tab [8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37, 7'h6F, 7'h67};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int   f3;
    logic b5;
    e  = '0;
    f3 = int'(ins[14:12]);
    b5 = ins[30];
    case (ins[6:0])
      7'h03: begin e.regw = 1; e.asrc = 1; e.rsrc = 2'd1; e.imm = 3'd0; e.alu = 4'd0; end
      7'h23: begin e.memw = 1; e.asrc = 1; e.imm = 3'd1; e.alu = 4'd0; end
      7'h33: begin
        e.regw = 1;
        e.alu  = 4'(alu_tab[f3]);
        if (f3 == 5 && b5) e.alu = 4'd9;
        if (f3 == 0 && b5) e.alu = 4'd1;
      end
      7'h13: begin
        e.regw = 1; e.asrc = 1; e.imm = 3'd0;
        e.alu  = 4'(alu_tab[f3]);
        if (f3 == 5 && b5) e.alu = 4'd9;
      end
      7'h63: begin e.br = 1; e.imm = 3'd2; e.alu = 4'd1; end
      7'h37: begin e.regw = 1; e.asrc = 1; e.imm = 3'd4; e.alu = 4'd10; end
`ifdef CU_JUMP_EN
      7'h6F: begin e.regw = 1; e.jmp = 1; e.rsrc = 2'd2; e.imm = 3'd3; end
      7'h67: begin e.regw = 1; e.jmp = 1; e.asrc = 1; e.rsrc = 2'd2; e.imm = 3'd0; e.alu = 4'd0; end
`endif
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic compare();
    check("valid_o",   32'(bus.valid_o),       32'(m.valid));
    check("regwrite",  32'(bus.regwriteE),     32'(m.regw));
    check("resultsrc", 32'(bus.resultsrcE),    32'(m.rsrc));
    check("memwrite",  32'(bus.memwriteE),     32'(m.memw));
    check("branch",    32'(bus.branchE),       32'(m.br));
    check("jump",      32'(bus.jumpE),         32'(m.jmp));
    check("alusrc",    32'(bus.alusrcE),       32'(m.asrc));
    check("immsrc",    32'(bus.immsrcE),       32'(m.imm));
    check("aluctrl",   32'(bus.alucontrolE),   32'(m.alu));
    check("illegal",   32'(bus.illegal_o),     32'(m.ill));
    check("ill_cnt",   32'(bus.illegal_cnt_o), 32'(mcnt));
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic f);
    bus.instr_i = ins;
    bus.valid_i = v;
    bus.stall_i = s;
    bus.flush_i = f;
  endtask

  // Advance one edge: check ready, update the model from the applied inputs, then compare.
  task automatic tick();
    exp_t nx;
    #1;
    check("ready_o", 32'(bus.ready_o), 32'(!bus.stall_i));
    nx = ref_decode(bus.instr_i);
    if (rst) begin
      m    = '0;
      mcnt = 0;
    end else if (bus.flush_i) begin
      m = '0;
    end else if (!bus.stall_i) begin
      if (bus.valid_i) begin
        m       = nx;
        m.valid = 1'b1;
        if (nx.ill && mcnt < CMAX) mcnt++;
      end else begin
        m = '0;
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 8) r[6:0] = op_tab[k];
    return r;
  endfunction

  initial begin
    m    = '0;
    mcnt = 0;
    rst  = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // sub x10, x10, x11
    drive(32'h40B50533, 1'b1, 1'b0, 1'b0);
    tick();
    check("sub.alu", 32'(bus.alucontrolE), 32'd1);
    check("sub.asrc", 32'(bus.alusrcE), 32'd0);

    // lw captured, then held by three stalled cycles with new instructions offered
    drive(32'h00052283, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(rnd_instr(), 1'b1, 1'b1, 1'b0);
      tick();
      check("lw_hold.rsrc", 32'(bus.resultsrcE), 32'd1);
      check("lw_hold.asrc", 32'(bus.alusrcE), 32'd1);
    end

    // flush wins over stall
    drive(32'h40B50533, 1'b1, 1'b1, 1'b1);
    tick();
    check("flush_stall.valid", 32'(bus.valid_o), 32'd0);

    // JAL
    drive(32'h008000EF, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef CU_JUMP_EN
    check("jal.jump", 32'(bus.jumpE), 32'd1);
    check("jal.imm", 32'(bus.immsrcE), 32'd3);
`else
    check("jal.ill", 32'(bus.illegal_o), 32'd1);
    check("jal.cnt", 32'(bus.illegal_cnt_o), 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(rnd_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0));
      tick();
    end

    // counter saturation from a clean reset
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive({$urandom} & 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("sat.cnt", 32'(bus.illegal_cnt_o), 32'd255);

    // reset during a stall with a nonzero count
    drive(32'h00052283, 1'b1, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_stall.cnt", 32'(bus.illegal_cnt_o), 32'd0);
    check("rst_stall.valid", 32'(bus.valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/control_unit_pipe.md
CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4, ALU control width (>=4; codes zero-extended).
REQ-002 SHALL have parameter CNT_W, default 8, illegal-instruction counter width.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_i  in  32  D-stage instruction.
- valid_i  in  1  instr_i valid.
- ready_o  out  1  capture possible.
- stall_i  in  1  hold E-stage register.
- flush_i  in  1  kill E-stage register.
- valid_o  out  1  E-stage entry valid.
- regwriteE  out  1  register write enable.
- resultsrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- memwriteE  out  1  store enable.
- branchE  out  1  conditional branch.
- jumpE  out  1  unconditional jump.
- alusrcE  out  1  0 reg, 1 immediate.
- immsrcE  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alucontrolE  out  ALUCTRL_W  ALU operation.
- illegal_o  out  1  entry is an illegal instruction.
- illegal_cnt_o  out  CNT_W  accepted illegal count.

Function
REQ-004 SHALL decode opcode=instr_i[6:0], funct3=[14:12], funct7b5=[30] combinationally; all E outputs registered, latency 1 cycle.
REQ-005 SHALL drive ready_o = !stall_i, combinational.
REQ-006 SHALL use ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
REQ-007 SHALL decode load 0000011: regwrite, alusrc, resultsrc 01, imm I, ADD.
REQ-008 SHALL decode store 0100011: memwrite, alusrc, imm S, ADD.
REQ-009 SHALL decode R-type 0110011: regwrite; funct3 000 -> SUB if funct7b5 else ADD; 101 -> SRA if funct7b5 else SRL; 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
REQ-010 SHALL decode I-ALU 0010011: regwrite, alusrc, resultsrc 00, imm I; as R-type except funct3 000 always ADD.
REQ-011 SHALL decode branch 1100011: branch, imm B, SUB.
REQ-012 SHALL decode LUI 0110111: regwrite, alusrc, imm U, PASSB.
REQ-013 SHALL treat any other opcode as illegal: all enables 0, illegal flag 1.
REQ-014 SHALL on each edge apply priority rst > flush_i > stall_i > capture.
REQ-015 SHALL on flush_i clear valid_o, illegal_o and all control outputs to 0, regardless of stall_i.
REQ-016 SHALL on stall_i (no flush) hold all E outputs and the counter unchanged.
REQ-017 SHALL on capture (no stall/flush) load decoded values with valid_o=valid_i; if valid_i=0 load a bubble (all 0).
REQ-018 SHALL increment illegal_cnt_o on each captured valid illegal instruction, saturating at all-ones; flushed entries are not uncounted.
REQ-019 SHALL keep all unused outputs 0 for non-illegal, non-valid entries.

Reset
REQ-020 SHALL on rst force valid_o, illegal_o, every control output and illegal_cnt_o to 0 on the next edge, overriding stall_i/flush_i, including mid-stall.

Configuration
REQ-021 SHALL, with CU_JUMP_EN defined, decode JAL 1101111 (regwrite, jump, resultsrc 10, imm J) and JALR 1100111 (regwrite, jump, alusrc, resultsrc 10, imm I, ADD).
REQ-022 SHALL, without CU_JUMP_EN, treat 1101111/1100111 as illegal and tie jumpE to 0.

Verification
REQ-023 SHALL cover: instr 0x40B50533 (sub) valid -> next cycle valid_o=1, regwriteE=1, alucontrolE=1, alusrcE=0.
REQ-024 SHALL cover: lw 0x00052283 captured, then stall_i=1 three cycles with new instr -> outputs hold resultsrcE=01, alusrcE=1.
REQ-025 SHALL cover: stall_i=1 and flush_i=1 same cycle -> valid_o=0, all controls 0 next cycle.
REQ-026 SHALL cover: 260 valid opcodes 0000000 with CNT_W=8 -> illegal_o=1 each, illegal_cnt_o saturates 255.
REQ-027 SHALL cover: JAL 0x008000EF -> with CU_JUMP_EN jumpE=1, resultsrcE=10, immsrcE=011; without it illegal_o=1, cnt+1.
REQ-028 SHALL cover: rst=1 during stall with nonzero count -> all outputs and count 0 next edge.
